// File: rtl/calc_frame_rx.sv
// -----------------------------------------------------------------------------
// calc_frame_rx
//
// Serial frame receiver for the binary calculator's shift-register transmitter.
// Deserialises 32-bit frames (MSB first), taking one bit on each rising edge of
// the CLK-synchronous divided clock CLK_Tx while D_OUT_VALID is high. Each
// completed frame is unpacked into operand/result/selector/flag fields and
// held behind a valid/ack interface. Short frames, extra bits and unacknowledged
// frame overwrites are reported.
//
// Ports:
//   CLK          in   system clock (also clocks transmitter and divider)
//   RESET        in   synchronous, active-high reset
//   D_OUT        in   serial data from the transmitter
//   D_OUT_VALID  in   transmitter frame-active flag
//   CLK_Tx       in   divided transmit clock level; bits taken on its rising edge
//   FRAME_ACK    in   consumer acknowledges the held frame
//   FRAME_VALID  out  a complete frame is held on the field outputs
//   RX_A         out  frame[31:24]
//   RX_B         out  frame[23:16]
//   RX_RESULT    out  frame[15:8]
//   RX_SEL       out  frame[7:4]
//   RX_FLAGS     out  frame[3:0]
//   ERR_SHORT    out  one-cycle pulse: frame ended before 32 bits
//   ERR_LONG     out  one-cycle pulse per extra bit after the 32nd
//   OVERRUN      out  sticky: a frame completed while the previous was unacked
//   FRAME_CNT    out  good-frame counter (wraps at 16 bits)
//
// Build option:
//   CALC_FRAME_RX_CNT_EN  defined   -> FRAME_CNT counts completed frames
//                         undefined -> no counter flops, FRAME_CNT = 16'h0000
// -----------------------------------------------------------------------------
module calc_frame_rx #(
  parameter int FRAME_W = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        D_OUT,
  input  logic        D_OUT_VALID,
  input  logic        CLK_Tx,
  input  logic        FRAME_ACK,
  output logic        FRAME_VALID,
  output logic [7:0]  RX_A,
  output logic [7:0]  RX_B,
  output logic [7:0]  RX_RESULT,
  output logic [3:0]  RX_SEL,
  output logic [3:0]  RX_FLAGS,
  output logic        ERR_SHORT,
  output logic        ERR_LONG,
  output logic        OVERRUN,
  output logic [15:0] FRAME_CNT
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]         r_state;
  logic [5:0]         r_bit_cnt;
  logic [FRAME_W-1:0] r_shreg;
  logic               r_ctx_q;

  logic               r_frame_valid;
  logic [7:0]         r_rx_a;
  logic [7:0]         r_rx_b;
  logic [7:0]         r_rx_result;
  logic [3:0]         r_rx_sel;
  logic [3:0]         r_rx_flags;
  logic               r_err_short;
  logic               r_err_long;
  logic               r_overrun;

  logic               w_bit_stb;
  logic               w_last_bit;
  logic               w_done;
  logic [FRAME_W-1:0] w_frame_next;

  // A rising CLK_Tx only counts as a bit while the transmitter is active.
  assign w_bit_stb    = CLK_Tx & ~r_ctx_q & D_OUT_VALID;
  assign w_frame_next = {r_shreg[FRAME_W-2:0], D_OUT};
  assign w_last_bit   = (r_bit_cnt == 6'(FRAME_W - 1));
  assign w_done       = (r_state == S_RECV) && w_bit_stb && w_last_bit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_ctx_q       <= 1'b0;
      r_frame_valid <= 1'b0;
      r_rx_a        <= '0;
      r_rx_b        <= '0;
      r_rx_result   <= '0;
      r_rx_sel      <= '0;
      r_rx_flags    <= '0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_ctx_q     <= CLK_Tx;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_bit_stb) begin
            r_shreg   <= w_frame_next;
            r_bit_cnt <= 6'd1;
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          // Count is always below 32 here, so losing valid is always short.
          if (!D_OUT_VALID) begin
            r_err_short <= 1'b1;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_state     <= S_IDLE;
          end else if (w_bit_stb) begin
            r_shreg   <= w_frame_next;
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (w_last_bit) begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!D_OUT_VALID) begin
            r_bit_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (w_bit_stb) begin
            r_err_long <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Completion wins over ack: a frame landing in the ack cycle stays valid.
      if (w_done) begin
        r_rx_a        <= w_frame_next[31:24];
        r_rx_b        <= w_frame_next[23:16];
        r_rx_result   <= w_frame_next[15:8];
        r_rx_sel      <= w_frame_next[7:4];
        r_rx_flags    <= w_frame_next[3:0];
        r_frame_valid <= 1'b1;
        if (r_frame_valid && !FRAME_ACK) begin
          r_overrun <= 1'b1;
        end
      end else if (FRAME_ACK) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

`ifdef CALC_FRAME_RX_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_frame_cnt <= '0;
    end else if (w_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign FRAME_CNT = r_frame_cnt;
`else
  assign FRAME_CNT = 16'h0000;
`endif

  assign FRAME_VALID = r_frame_valid;
  assign RX_A        = r_rx_a;
  assign RX_B        = r_rx_b;
  assign RX_RESULT   = r_rx_result;
  assign RX_SEL      = r_rx_sel;
  assign RX_FLAGS    = r_rx_flags;
  assign ERR_SHORT   = r_err_short;
  assign ERR_LONG    = r_err_long;
  assign OVERRUN     = r_overrun;

endmodule

// File: tb/tb_calc_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_calc_frame_rx
//
// Self-checking bench for calc_frame_rx. Frames are serialised MSB first with a
// configurable CLK_Tx high/low shape; each fully sent frame is pushed onto an
// expected-frame queue and popped when the receiver presents it.
// -----------------------------------------------------------------------------
module tb_calc_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_out;
  logic        d_out_valid;
  logic        clk_tx;
  logic        frame_ack;
  logic        frame_valid;
  logic [7:0]  rx_a;
  logic [7:0]  rx_b;
  logic [7:0]  rx_result;
  logic [3:0]  rx_sel;
  logic [3:0]  rx_flags;
  logic        err_short;
  logic        err_long;
  logic        overrun;
  logic [15:0] frame_cnt;

`ifdef CALC_FRAME_RX_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          short_cnt = 0;
  int          long_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_cnt = 16'h0000;
  logic [31:0] exp_frame;
  logic [31:0] held;

  calc_frame_rx dut (
    .CLK         (clk),
    .RESET       (rst),
    .D_OUT       (d_out),
    .D_OUT_VALID (d_out_valid),
    .CLK_Tx      (clk_tx),
    .FRAME_ACK   (frame_ack),
    .FRAME_VALID (frame_valid),
    .RX_A        (rx_a),
    .RX_B        (rx_b),
    .RX_RESULT   (rx_result),
    .RX_SEL      (rx_sel),
    .RX_FLAGS    (rx_flags),
    .ERR_SHORT   (err_short),
    .ERR_LONG    (err_long),
    .OVERRUN     (overrun),
    .FRAME_CNT   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Each error output is a one-cycle pulse, so each pulse is counted once.
  always @(posedge clk) begin
    if (err_short === 1'b1) short_cnt++;
    if (err_long === 1'b1) long_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send nbits bits of data MSB first; bits past 32 are zeros.
  task automatic send_frame(input logic [31:0] data, input int nbits, input int hi,
                            input int lo, input bit ack_last, input bit end_frame);
    d_out_valid = 1'b1;
    clk_tx      = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      d_out  = (i < 32) ? data[31-i] : 1'b0;
      clk_tx = 1'b1;
      if (ack_last && i == nbits - 1) frame_ack = 1'b1;
      for (int h = 0; h < hi; h++) begin
        tick();
        frame_ack = 1'b0;
      end
      clk_tx = 1'b0;
      for (int l = 0; l < lo; l++) tick();
    end
    if (nbits >= 32) begin
      exp_q.push_back(data);
      if (CNT_EN) exp_cnt = exp_cnt + 16'd1;
    end
    if (end_frame) begin
      d_out_valid = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    d_out       = 1'b0;
    d_out_valid = 1'b0;
    clk_tx      = 1'b0;
    frame_ack   = 1'b0;
    tick();
    tick();
    rst     = 1'b0;
    exp_cnt = 16'h0000;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({frame_valid, rx_a, rx_b, rx_result, rx_sel, rx_flags, err_short, err_long, overrun, frame_cnt} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got fv=%b fields=%h es=%b el=%b ov=%b cnt=%h, want all zero",
               frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, err_short, err_long, overrun, frame_cnt);
    end
  endtask

  task automatic test_good_frame();
    send_frame(32'h1234_460A, 32, 2, 2, 1'b0, 1'b1);
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL good_valid: got %b want 1", frame_valid);
    end
    n_tests++;
    if ({rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || exp_frame !== 32'h1234_460A) begin
      n_fail++; $display("FAIL good_fields: got %h want %h", {rx_a, rx_b, rx_result, rx_sel, rx_flags}, exp_frame);
    end
    n_tests++;
    if (frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL good_cnt: got %h want %h", frame_cnt, exp_cnt);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_tests++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL ack_clears: got %b want 0", frame_valid);
    end
    n_tests++;
    if ({rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame) begin
      n_fail++; $display("FAIL ack_fields_held: got %h want %h", {rx_a, rx_b, rx_result, rx_sel, rx_flags}, exp_frame);
    end
    held = exp_frame;
  endtask

  task automatic test_short_frame();
    int s0;
    s0 = short_cnt;
    send_frame(32'hDEAD_BEEF, 20, 2, 2, 1'b0, 1'b0);
    d_out_valid = 1'b0;
    tick();
    n_tests++;
    if (err_short !== 1'b1) begin
      n_fail++; $display("FAIL short_pulse_rise: got %b want 1", err_short);
    end
    tick();
    n_tests++;
    if (err_short !== 1'b0 || short_cnt - s0 != 1) begin
      n_fail++; $display("FAIL short_pulse_width: got es=%b pulses=%0d want es=0 pulses=1", err_short, short_cnt - s0);
    end
    n_tests++;
    if ({frame_valid, rx_a, rx_b, rx_result, rx_sel, rx_flags} !== {1'b0, held} || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL short_unchanged: got fv=%b fields=%h cnt=%h want fv=0 fields=%h cnt=%h",
                         frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, frame_cnt, held, exp_cnt);
    end
    send_frame(32'hFFFF_FFFF, 32, 2, 2, 1'b0, 1'b1);
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (frame_valid !== 1'b1 || {rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL after_short_frame: got fv=%b fields=%h cnt=%h want fv=1 fields=%h cnt=%h",
                         frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, frame_cnt, exp_frame, exp_cnt);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_long_frame();
    int l0;
    l0 = long_cnt;
    send_frame(32'h5A5A_F00F, 33, 2, 2, 1'b0, 1'b1);
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (long_cnt - l0 != 1) begin
      n_fail++; $display("FAIL long_pulses: got %0d want 1", long_cnt - l0);
    end
    n_tests++;
    if (frame_valid !== 1'b1 || {rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL long_fields: got fv=%b fields=%h cnt=%h want fv=1 fields=%h cnt=%h",
                         frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, frame_cnt, exp_frame, exp_cnt);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(32'hAAAA_AAAA, 32, 2, 2, 1'b0, 1'b1);
    send_frame(32'h5555_5555, 32, 2, 2, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set: got %b want 1", overrun);
    end
    n_tests++;
    if ({rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL overrun_fields: got fields=%h cnt=%h want fields=%h cnt=%h",
                         {rx_a, rx_b, rx_result, rx_sel, rx_flags}, frame_cnt, exp_frame, exp_cnt);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
  endtask

  task automatic test_ack_on_completion();
    do_reset();
    send_frame(32'hAAAA_AAAA, 32, 2, 2, 1'b0, 1'b1);
    send_frame(32'h5555_5555, 32, 2, 2, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (overrun !== 1'b0 || frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL ack_same_cycle: got ov=%b fv=%b want ov=0 fv=1", overrun, frame_valid);
    end
    n_tests++;
    if ({rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL ack_same_fields: got fields=%h cnt=%h want fields=%h cnt=%h",
                         {rx_a, rx_b, rx_result, rx_sel, rx_flags}, frame_cnt, exp_frame, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    int l0;
    s0 = short_cnt;
    l0 = long_cnt;
    send_frame(32'hFFFF_FFFF, 10, 2, 2, 1'b0, 1'b0);
    rst         = 1'b1;
    d_out_valid = 1'b0;
    tick();
    n_tests++;
    if ({frame_valid, rx_a, rx_b, rx_result, rx_sel, rx_flags, err_short, err_long, overrun, frame_cnt} !== 52'h0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got fv=%b fields=%h ov=%b cnt=%h want all zero",
                         frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, overrun, frame_cnt);
    end
    tick();
    rst     = 1'b0;
    exp_cnt = 16'h0000;
    tick();
    tick();
    send_frame(32'h0000_0001, 32, 2, 2, 1'b0, 1'b1);
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (short_cnt != s0 || long_cnt != l0) begin
      n_fail++; $display("FAIL reset_mid_no_err: got short=%0d long=%0d want 0 0", short_cnt - s0, long_cnt - l0);
    end
    n_tests++;
    if (frame_valid !== 1'b1 || {rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || rx_flags !== 4'h1) begin
      n_fail++; $display("FAIL reset_mid_decode: got fv=%b fields=%h want fv=1 fields=%h",
                         frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, exp_frame);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_div1();
    send_frame(32'hC3C3_C3C3, 32, 1, 1, 1'b0, 1'b1);
    exp_frame = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_tests++;
    if (frame_valid !== 1'b1 || {rx_a, rx_b, rx_result, rx_sel, rx_flags} !== exp_frame || frame_cnt !== exp_cnt) begin
      n_fail++; $display("FAIL div1_decode: got fv=%b fields=%h cnt=%h want fv=1 fields=%h cnt=%h",
                         frame_valid, {rx_a, rx_b, rx_result, rx_sel, rx_flags}, frame_cnt, exp_frame, exp_cnt);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_cnt_wrap();
`ifdef CALC_FRAME_RX_CNT_EN
    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    exp_cnt = 16'hFFFF;
    tick();
    send_frame(32'h0102_0304, 32, 1, 1, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    n_tests++;
    if (frame_cnt !== 16'h0000 || exp_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL cnt_wrap: got %h want 0000", frame_cnt);
    end
`else
    send_frame(32'h0102_0304, 32, 1, 1, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    n_tests++;
    if (frame_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL cnt_disabled: got %h want 0000", frame_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_long_frame();
    test_overrun();
    test_ack_on_completion();
    test_reset_mid_frame();
    test_div1();
    test_cnt_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
